// File: rtl/bandai2003_pkg.sv
// ----------------------------------------------------------------------------
// bandai2003_pkg: shared state encoding and bus address constants.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package bandai2003_pkg;

    localparam int FRAME_LEN = 18;

    localparam logic [7:0] ADDR_IDLE  = 8'h00;
    localparam logic [7:0] ADDR_ACK   = 8'h5A;
    localparam logic [7:0] ADDR_NAK   = 8'hA5;
    localparam logic [7:0] ADDR_BANK0 = 8'hC0;
    localparam logic [7:0] ADDR_BANK1 = 8'hC1;
    localparam logic [7:0] ADDR_BANK2 = 8'hC2;
    localparam logic [7:0] ADDR_BANK3 = 8'hC3;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_UNLK_ACK   = 4'd1,
        ST_UNLK_NAK   = 4'd2,
        ST_RX         = 4'd3,
        ST_CHECK      = 4'd4,
        ST_READY      = 4'd5,
        ST_BUS_SETUP  = 4'd6,
        ST_BUS_STROBE = 4'd7,
        ST_BUS_HOLD   = 4'd8,
        ST_FAIL       = 4'd9
    } state_t;

    function automatic logic [7:0] bank_addr(input logic [1:0] sel);
        return ADDR_BANK0 | {6'b0, sel};
    endfunction

endpackage

`default_nettype wire

// File: rtl/bandai2003_rx.sv
// ----------------------------------------------------------------------------
// bandai2003_rx: LSB-first serial frame capture with bit counter and done strobe.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bandai2003_rx #(
    parameter int FRAME_LEN = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 si,
    output logic [FRAME_LEN-1:0] frame,
    output logic                 done
);

    localparam int CNT_W = $clog2(FRAME_LEN);

    logic [CNT_W-1:0] count;

    // done marks the cycle whose closing edge takes the final sample
    assign done = en && (count == CNT_W'(FRAME_LEN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame <= '0;
            count <= '0;
        end else if (en) begin
            frame <= {si, frame[FRAME_LEN-1:1]};
            count <= done ? '0 : count + 1'b1;
        end else begin
            count <= '0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bandai2003_host.sv
// ----------------------------------------------------------------------------
// bandai2003_host: cartridge unlock handshake, payload check and bank access.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bandai2003_host
    import bandai2003_pkg::*;
#(
    parameter logic [15:0] EXP_PAYLOAD = 16'h28A0,
    parameter int          FRAME_LEN   = bandai2003_pkg::FRAME_LEN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        si,
    output logic [7:0]  addr,
    output logic        ce_n,
    output logic        ss_n,
    output logic        we_n,
    output logic        oe_n,
    output logic [7:0]  dq_o,
    output logic        dq_oe,
    input  logic [7:0]  dq_i,
    input  logic        req,
    input  logic        rw,
    input  logic [1:0]  sel,
    input  logic [7:0]  wdata,
    output logic        ack,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic        unlocked,
    output logic        err,
    output logic [15:0] payload
);

    state_t               state, next;
    logic [FRAME_LEN-1:0] frame;
    logic                 rx_done;
    logic                 frame_ok;
    logic                 rw_q;
    logic [1:0]           sel_q;
    logic [7:0]           wdata_q;
    logic                 bus_rw;
    logic [1:0]           bus_sel;
    logic [7:0]           bus_wdata;
    logic [7:0]           addr_d, dq_o_d;
    logic                 ss_n_d, we_n_d, oe_n_d, dq_oe_d;

    bandai2003_rx #(.FRAME_LEN(FRAME_LEN)) u_rx (
        .clk   (clk),
        .rst   (rst),
        .en    (state == ST_RX),
        .si    (si),
        .frame (frame),
        .done  (rx_done)
    );

    assign frame_ok = !frame[0] && !frame[FRAME_LEN-1] && (frame[16:1] == EXP_PAYLOAD);

    // Outputs are registered from the next state, so the request fields must
    // come straight from the ports on the edge that leaves READY.
    assign bus_rw    = (state == ST_READY) ? rw    : rw_q;
    assign bus_sel   = (state == ST_READY) ? sel   : sel_q;
    assign bus_wdata = (state == ST_READY) ? wdata : wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next;
    end

    always_comb begin
        next    = state;
        addr_d  = ADDR_IDLE;
        ss_n_d  = 1'b1;
        we_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        dq_o_d  = 8'h00;
        unique case (state)
            ST_IDLE:       if (start) next = ST_UNLK_ACK;
            ST_UNLK_ACK:   next = ST_UNLK_NAK;
            ST_UNLK_NAK:   next = ST_RX;
            ST_RX:         if (rx_done) next = ST_CHECK;
            ST_CHECK:      next = frame_ok ? ST_READY : ST_FAIL;
            ST_READY:      if (req) next = ST_BUS_SETUP;
            ST_BUS_SETUP:  next = ST_BUS_STROBE;
            ST_BUS_STROBE: next = ST_BUS_HOLD;
            ST_BUS_HOLD:   next = ST_READY;
            ST_FAIL:       next = ST_FAIL;
            default:       next = ST_IDLE;
        endcase
        unique case (next)
            ST_UNLK_ACK: addr_d = ADDR_ACK;
            ST_UNLK_NAK: addr_d = ADDR_NAK;
            ST_BUS_SETUP, ST_BUS_STROBE, ST_BUS_HOLD: begin
                addr_d  = bank_addr(bus_sel);
                ss_n_d  = 1'b0;
                dq_oe_d = !bus_rw;
                dq_o_d  = bus_wdata;
                if (next == ST_BUS_STROBE) begin
                    we_n_d = bus_rw;
                    oe_n_d = !bus_rw;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr     <= ADDR_IDLE;
            ce_n     <= 1'b1;
            ss_n     <= 1'b1;
            we_n     <= 1'b1;
            oe_n     <= 1'b1;
            dq_oe    <= 1'b0;
            dq_o     <= 8'h00;
            ack      <= 1'b0;
            rdata    <= 8'h00;
            busy     <= 1'b0;
            unlocked <= 1'b0;
            err      <= 1'b0;
            payload  <= 16'h0000;
            rw_q     <= 1'b0;
            sel_q    <= 2'b00;
            wdata_q  <= 8'h00;
        end else begin
            addr     <= addr_d;
            ce_n     <= 1'b1;
            ss_n     <= ss_n_d;
            we_n     <= we_n_d;
            oe_n     <= oe_n_d;
            dq_oe    <= dq_oe_d;
            dq_o     <= dq_o_d;
            ack      <= (state == ST_BUS_HOLD);
            busy     <= !(next inside {ST_IDLE, ST_READY, ST_FAIL});
            unlocked <= (next inside {ST_READY, ST_BUS_SETUP, ST_BUS_STROBE, ST_BUS_HOLD});
            err      <= (next == ST_FAIL);
            if (state == ST_CHECK) payload <= frame[16:1];
            if (state == ST_BUS_STROBE && rw_q) rdata <= dq_i;
            if (state == ST_READY && req) begin
                rw_q    <= rw;
                sel_q   <= sel;
                wdata_q <= wdata;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bandai2003_host.sv
// ----------------------------------------------------------------------------
// tb_bandai2003_host: cartridge model plus scoreboard for bandai2003_host.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_bandai2003_host;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        si = 1'b1;
    logic [7:0]  addr;
    logic        ce_n, ss_n, we_n, oe_n;
    logic [7:0]  dq_o;
    logic        dq_oe;
    logic [7:0]  dq_i;
    logic        req = 1'b0;
    logic        rw = 1'b0;
    logic [1:0]  sel = 2'b00;
    logic [7:0]  wdata = 8'h00;
    logic        ack;
    logic [7:0]  rdata;
    logic        busy, unlocked, err;
    logic [15:0] payload;

    bandai2003_host dut (
        .clk(clk), .rst(rst), .start(start), .si(si), .addr(addr),
        .ce_n(ce_n), .ss_n(ss_n), .we_n(we_n), .oe_n(oe_n),
        .dq_o(dq_o), .dq_oe(dq_oe), .dq_i(dq_i),
        .req(req), .rw(rw), .sel(sel), .wdata(wdata),
        .ack(ack), .rdata(rdata), .busy(busy), .unlocked(unlocked),
        .err(err), .payload(payload)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Cartridge model: banks, write on WEn rising edge, frame after A5
    logic [7:0]  bank [4] = '{8'h11, 8'h55, 8'h22, 8'h33};
    logic        stop_bit = 1'b0;
    logic [17:0] frame_bits;

    assign dq_i = (!ss_n && !oe_n) ? bank[addr[1:0]] : 8'hFF;

    always @(posedge we_n) if (!ss_n) bank[addr[1:0]] = dq_o;

    always @(negedge clk) begin
        if (addr == 8'hA5) begin
            frame_bits = {stop_bit, 16'h28A0, 1'b0};
            for (int i = 0; i < 18; i++) begin
                @(posedge clk);
                #1 si = frame_bits[i];
            end
        end
    end

    // Scoreboard and bus monitor
    typedef struct {
        int         ack_cyc;
        logic       rw;
        logic [7:0] data;
    } exp_t;
    exp_t sb[$];

    int cnt_5a = 0, cnt_ss = 0, cnt_we = 0, cnt_oe = 0, viol = 0;
    logic [7:0] last_bus_addr = 8'h00;

    always @(negedge clk) begin
        exp_t e;
        if (addr == 8'h5A) cnt_5a++;
        if (!ss_n) begin cnt_ss++; last_bus_addr = addr; end
        if (!we_n) cnt_we++;
        if (!oe_n) cnt_oe++;
        if ((!we_n && !oe_n) || !ce_n) viol++;
        if (ack) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("ack_latency", cyc, e.ack_cyc);
                if (e.rw) chk("rdata", rdata, e.data);
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_addr"}, addr, 8'h00);
        chk({tag, "_flags"}, {ce_n, ss_n, we_n, oe_n, dq_oe, ack, busy, unlocked, err},
            9'b1111_00000);
        chk({tag, "_dq_rdata"}, {dq_o, rdata}, 16'h0000);
        chk({tag, "_payload"}, payload, 16'h0000);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic unlock(input string tag, input logic exp_ok);
        int cs;
        @(negedge clk);
        cs = cyc;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk({tag, "_addr_ack"}, addr, 8'h5A);
        @(negedge clk);
        chk({tag, "_addr_nak"}, addr, 8'hA5);
        chk({tag, "_busy"}, busy, 1'b1);
        for (int i = 0; i < 40; i++) begin
            if (unlocked || err) break;
            @(negedge clk);
        end
        chk({tag, "_done_cycle"}, cyc - cs, 22);
        chk({tag, "_status"}, {busy, unlocked, err}, {1'b0, exp_ok, !exp_ok});
        if (exp_ok) chk({tag, "_payload"}, payload, 16'h28A0);
    endtask

    task automatic bus(input logic r, input logic [1:0] s, input logic [7:0] d,
                       input logic [7:0] exp);
        int we0, oe0, ss0;
        we0 = cnt_we; oe0 = cnt_oe; ss0 = cnt_ss;
        @(negedge clk);
        req = 1'b1; rw = r; sel = s; wdata = d;
        sb.push_back('{cyc + 4, r, exp});
        @(posedge clk);
        #1 req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) break;
        end
        chk("ack_timeout", sb.size(), 0);
        sb.delete();
        chk("bus_addr", last_bus_addr, {6'b110000, s});
        chk("ss_low_cycles", cnt_ss - ss0, 3);
        chk("we_low_cycles", cnt_we - we0, r ? 0 : 1);
        chk("oe_low_cycles", cnt_oe - oe0, r ? 1 : 0);
    endtask

    initial begin
        int cs, n5a, nss;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;

        // REQ before unlock must be ignored
        nss = cnt_ss;
        @(negedge clk); req = 1'b1; rw = 1'b0;
        repeat (3) @(negedge clk);
        req = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_req_ignored", cnt_ss - nss, 0);

        unlock("unlock1", 1'b1);

        bus(1'b0, 2'd2, 8'h3C, 8'h00);
        chk("bank2_written", bank[2], 8'h3C);
        bus(1'b1, 2'd2, 8'h00, 8'h3C);
        bus(1'b0, 2'd0, 8'hA7, 8'h00);
        bus(1'b1, 2'd0, 8'h00, 8'hA7);
        bus(1'b1, 2'd1, 8'h00, 8'h55);

        // Reset in the 9th RX cycle, then a fresh unlock
        do_reset();
        @(negedge clk);
        cs = cyc;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while (cyc < cs + 11) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_vals("rx_reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        unlock("unlock2", 1'b1);

        // START and REQ held through the whole unlock
        do_reset();
        n5a = cnt_5a;
        @(negedge clk);
        cs = cyc;
        start = 1'b1; req = 1'b1; rw = 1'b0; sel = 2'd1; wdata = 8'h99;
        sb.push_back('{cs + 26, 1'b0, 8'h00});
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ack) break;
        end
        start = 1'b0; req = 1'b0;
        repeat (3) @(negedge clk);
        chk("held_ack_seen", sb.size(), 0);
        sb.delete();
        chk("held_single_unlock", cnt_5a - n5a, 1);
        chk("held_bank1", bank[1], 8'h99);

        // Bad stop bit: sticky failure, no further activity
        do_reset();
        stop_bit = 1'b1;
        unlock("bad_stop", 1'b0);
        n5a = cnt_5a; nss = cnt_ss;
        @(negedge clk);
        start = 1'b1; req = 1'b1; rw = 1'b1;
        repeat (5) @(negedge clk);
        start = 1'b0; req = 1'b0;
        repeat (25) @(negedge clk);
        chk("fail_no_unlock", cnt_5a - n5a, 0);
        chk("fail_no_bus", cnt_ss - nss, 0);
        chk("fail_sticky", {busy, unlocked, err}, 3'b001);

        chk("strobe_protocol", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=1 expected=0");
        $fatal(1, "simulation time limit reached");
    end

endmodule

`default_nettype wire

// File: doc/bandai2003_host.md
BANDAI2003_HOST -- requirements
Module: bandai2003_host

Interface
REQ-001 The block SHALL have parameter EXP_PAYLOAD, default 16'h28A0, the 16-bit payload required for a successful unlock.
REQ-002 The block SHALL have parameter FRAME_LEN, default 18, the number of serial bits captured: start + 16 payload + stop.
REQ-003 CLK  in  1  system clock; every register updates on the rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-high.
REQ-005 START  in  1  one-cycle request to run the unlock sequence.
REQ-006 SI  in  1  serial input, connected to the cartridge SO.
REQ-007 ADDR  out  8  cartridge address bus, registered.
REQ-008 CEn, SSn, WEn, OEn  out  1 each  cartridge strobes, active-low, registered.
REQ-009 DQ_O  out  8  write data; DQ_OE  out  1  DQ drive enable.
REQ-010 DQ_I  in  8  read data from the cartridge.
REQ-011 REQ  in  1  bank access request; RW  in  1  (1 = read); SEL  in  2  bank index; WDATA  in  8  write data.
REQ-012 ACK  out  1  one-cycle access done; RDATA  out  8  read result.
REQ-013 BUSY, UNLOCKED, ERR  out  1 each  status; PAYLOAD  out  16  captured payload.

Function
REQ-014 The state machine SHALL have states IDLE, UNLK_ACK, UNLK_NAK, RX, CHECK, READY, BUS_SETUP, BUS_STROBE, BUS_HOLD and FAIL.
REQ-015 In IDLE, START=1 SHALL move to UNLK_ACK; START SHALL be ignored in every other state.
REQ-016 UNLK_ACK SHALL drive ADDR=8'h5A for exactly one cycle; UNLK_NAK SHALL then drive ADDR=8'hA5 for exactly one cycle; RX SHALL follow.
REQ-017 Outside UNLK_ACK, UNLK_NAK and bus states, ADDR SHALL be 8'h00, so it never matches 5A or A5.
REQ-018 RX SHALL sample SI at the end of each of FRAME_LEN consecutive cycles, storing sample i at frame bit i (LSB first).
REQ-019 The first RX sample SHALL be the start bit, taken on the edge that ends the first RX cycle; there is no idle gap.
REQ-020 CHECK SHALL last one cycle and load PAYLOAD = frame[16:1].
REQ-021 CHECK SHALL move to READY, setting UNLOCKED=1, if frame[0]=0, frame[17]=0 and PAYLOAD=EXP_PAYLOAD.
REQ-022 If any CHECK condition fails, CHECK SHALL move to FAIL and set ERR=1.
REQ-023 FAIL SHALL be sticky until RST, because the cartridge does not re-arm without reset.
REQ-024 BUSY SHALL be 1 in all states except IDLE, READY and FAIL.
REQ-025 In READY, REQ=1 SHALL latch RW, SEL and WDATA and enter BUS_SETUP.
REQ-026 REQ outside READY SHALL be ignored (not queued).
REQ-027 BUS_SETUP SHALL drive ADDR=8'hC0|SEL, SSn=0, CEn=1, WEn=1, OEn=1, and DQ_OE=RW?0:1 with DQ_O=WDATA.
REQ-028 For a write, BUS_STROBE SHALL drive WEn=0.
REQ-029 For a read, BUS_STROBE SHALL drive OEn=0 and WEn=1, and RDATA SHALL capture DQ_I on the edge ending BUS_STROBE.
REQ-030 BUS_HOLD SHALL restore WEn=1 and OEn=1 while keeping ADDR, SSn and DQ_OE; the WEn rising edge commits a write.
REQ-031 The exit from BUS_HOLD SHALL pulse ACK=1 for one cycle, release SSn=1 and DQ_OE=0, and return to READY.
REQ-032 Access latency SHALL be 4 cycles from REQ sampled to ACK.
REQ-033 CEn SHALL remain 1 in every state.
REQ-034 WEn=0 and OEn=0 SHALL never be asserted together.

Reset
REQ-035 RST SHALL immediately force ADDR=00, CEn=SSn=WEn=OEn=1, DQ_OE=0, DQ_O=00, ACK=0, RDATA=00, BUSY=0, UNLOCKED=0, ERR=0, PAYLOAD=0000 and state=IDLE.
REQ-036 RST mid-RX or mid-bus-cycle SHALL abandon the operation with no ACK, and the frame SHALL be discarded.

Structure
REQ-037 Package bandai2003_pkg SHALL hold the state enum, the address constants 8'h5A, 8'hA5 and 8'hC0–8'hC3, and FRAME_LEN.
REQ-038 Sub-module bandai2003_rx SHALL implement the FRAME_LEN-bit LSB-first capture shift register and bit counter with a done strobe.
REQ-039 The top-level module SHALL hold the FSM and the bus sequencer.

Verification
REQ-040 Cartridge model plus START -> ADDR 5A, then A5 on consecutive cycles; 18 cycles later PAYLOAD=16'h28A0, UNLOCKED=1, ERR=0.
REQ-041 Model stop bit forced to 1 -> ERR=1, state FAIL; a later START and REQ produce no bus activity.
REQ-042 REQ write SEL=2, WDATA=8'h3C -> ADDR=C2 with SSn=0, one WEn low cycle, ACK 4 cycles after REQ, model bank 2 = 3C.
REQ-043 REQ read SEL=2 after REQ-042 -> OEn low one cycle, RDATA=8'h3C, WEn stays 1.
REQ-044 RST asserted in the 9th RX cycle -> all outputs at reset values that same cycle; a new START after release of both blocks -> full unlock.
REQ-045 START and REQ held high throughout the unlock -> exactly one unlock sequence; REQ is first honoured in READY.
